rate_window_counter: RTL and testbench

- Upstream feeder for the slow serial reciprocal divider.
- Counts event pulses over a programmable window of clk_i cycles. At window end it presents the count as the divisor, pulses the divider's calc input, and holds the divisor stable until the divider reports valid.
- Divider output (2^NBITS/count) is therefore a period/rate estimate per window. Zero counts are flagged and never sent to the divider.

---
 rtl/rate_window_pkg.sv | 45 ++++
 rtl/rate_window_counter_if.sv | 42 ++++
 rtl/window_timer.sv | 28 ++
 rtl/rate_window_counter.sv | 147 ++++++++++++++
 tb/tb_rate_window_counter.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rate_window_pkg.sv
// Shared types and the saturating-increment helper for the rate window counter.
package rate_window_pkg;

    // Internal width used by sat_inc; NBITS up to this value is supported.
    localparam int SAT_W = 32;

    typedef enum logic {
        WIN_IDLE,
        WIN_RUN
    } win_state_t;

    typedef enum logic {
        HS_READY,
        HS_WAIT
    } hs_state_t;

    typedef struct packed {
        logic [SAT_W-1:0] sum;
        logic             ovf;
    } sat_res_t;

    // Adds inc to count, clamping at 2^nbits-1. ovf flags an increment that
    // was refused because count was already at the ceiling.
    function automatic sat_res_t sat_inc(input logic [SAT_W-1:0] count,
                                         input logic inc,
                                         input int nbits);
        logic [SAT_W-1:0] max_val;
        sat_res_t         res;
        max_val = '1;
        if (nbits < SAT_W) begin
            max_val = ~({SAT_W{1'b1}} << nbits);
        end
        res.sum = count;
        res.ovf = 1'b0;
        if (inc) begin
            if (count >= max_val) begin
                res.ovf = 1'b1;
            end else begin
                res.sum = count + SAT_W'(1);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rate_window_counter_if.sv
// Signal bundle between the rate window counter, its controller and the divider.
//
// Divider handshake: calc_o is a one-cycle start strobe, issued only while
// busy_o is low. From that strobe until the divider's recip_valid_i is sampled
// high, busy_o stays high and count_o is frozen. recip_valid_i is only
// meaningful while busy_o is high; any other recip_valid_i pulse is ignored.
// busy_o drops on the edge that samples recip_valid_i.
interface rate_window_counter_if #(
    parameter int NBITS       = 16,
    parameter int WINDOW_BITS = 24
);
    import rate_window_pkg::*;

    logic                   enable_i;
    logic [WINDOW_BITS-1:0] window_len_i;
    logic                   event_i;
    logic                   recip_valid_i;

    logic [NBITS-1:0]       count_o;
    logic                   calc_o;
    logic                   busy_o;
    logic                   zero_o;
    logic                   overflow_o;
    logic                   missed_o;

    // Debug view of both FSMs.
    win_state_t             win_state;
    hs_state_t              hs_state;

    modport master (
        output enable_i, window_len_i, event_i, recip_valid_i,
        input  count_o, calc_o, busy_o, zero_o, overflow_o, missed_o,
        input  win_state, hs_state
    );

    modport slave (
        input  enable_i, window_len_i, event_i, recip_valid_i,
        output count_o, calc_o, busy_o, zero_o, overflow_o, missed_o,
        output win_state, hs_state
    );

endinterface

// File: rtl/window_timer.sv
// Loadable down-counter that marks the last cycle of a window with tc.
module window_timer #(
    parameter int WINDOW_BITS = 24
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load,
    input  logic [WINDOW_BITS-1:0] load_value,
    input  logic                   dec,
    output logic                   tc
);

    logic [WINDOW_BITS-1:0] count;

    // Load takes priority over decrement; the counter parks at zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WINDOW_BITS'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/rate_window_counter.sv
// Counts event strobes over back-to-back windows and hands each non-zero
// count to the serial reciprocal divider, holding it until the divider is done.
module rate_window_counter
    import rate_window_pkg::*;
#(
    parameter int NBITS       = 16,
    parameter int WINDOW_BITS = 24
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    rate_window_counter_if.slave bus
);

    win_state_t             win_state;
    hs_state_t              hs_state;
    logic [NBITS-1:0]       acc;
    logic [NBITS-1:0]       count_q;
    logic                   calc_q;
    logic                   busy_q;
    logic                   zero_q;
    logic                   overflow_q;
    logic                   missed_q;

    logic                   timer_load;
    logic                   timer_dec;
    logic                   timer_tc;
    logic [WINDOW_BITS-1:0] load_value;
    sat_res_t               sat_res;
    logic [NBITS-1:0]       next_count;
    logic                   next_ovf;
    logic                   running;
    logic                   terminal;
    logic                   issue_calc;
    logic                   unused_sat_bits;

    // Next accumulator value, window-end decision and timer control.
    always_comb begin
        load_value = '0;
        if (bus.window_len_i != '0) begin
            load_value = bus.window_len_i - WINDOW_BITS'(1);
        end
        sat_res    = sat_inc(SAT_W'(acc), bus.event_i, NBITS);
        next_count = sat_res.sum[NBITS-1:0];
        next_ovf   = sat_res.ovf;
        running    = (win_state == WIN_RUN) && bus.enable_i;
        terminal   = running && timer_tc;
        issue_calc = terminal && (next_count != '0) && !busy_q;
        timer_load = ((win_state == WIN_IDLE) && bus.enable_i) || terminal;
        timer_dec  = running && !timer_tc;
    end

    // Upper bits of the helper's wide sum are always zero here.
    assign unused_sat_bits = ^sat_res.sum;

    window_timer #(
        .WINDOW_BITS (WINDOW_BITS)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load       (timer_load),
        .load_value (load_value),
        .dec        (timer_dec),
        .tc         (timer_tc)
    );

    // Window FSM: accumulate events, classify each window end, sticky overflow.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            win_state  <= WIN_IDLE;
            acc        <= '0;
            zero_q     <= 1'b0;
            missed_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            zero_q   <= 1'b0;
            missed_q <= 1'b0;
            if (!bus.enable_i) begin
                overflow_q <= 1'b0;
            end
            case (win_state)
                WIN_IDLE: begin
                    if (bus.enable_i) begin
                        win_state <= WIN_RUN;
                        acc       <= '0;
                    end
                end
                WIN_RUN: begin
                    if (!bus.enable_i) begin
                        win_state <= WIN_IDLE;
                        acc       <= '0;
                    end else begin
                        if (next_ovf) begin
                            overflow_q <= 1'b1;
                        end
                        if (timer_tc) begin
                            acc      <= '0;
                            zero_q   <= (next_count == '0);
                            missed_q <= (next_count != '0) && busy_q;
                        end else begin
                            acc <= next_count;
                        end
                    end
                end
                default: win_state <= WIN_IDLE;
            endcase
        end
    end

    // Handshake FSM: launch the divider and freeze count_o until it answers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hs_state <= HS_READY;
            count_q  <= '0;
            calc_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            calc_q <= 1'b0;
            case (hs_state)
                HS_READY: begin
                    if (issue_calc) begin
                        hs_state <= HS_WAIT;
                        count_q  <= next_count;
                        calc_q   <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                HS_WAIT: begin
                    if (bus.recip_valid_i) begin
                        hs_state <= HS_READY;
                        busy_q   <= 1'b0;
                    end
                end
                default: hs_state <= HS_READY;
            endcase
        end
    end

    assign bus.count_o    = count_q;
    assign bus.calc_o     = calc_q;
    assign bus.busy_o     = busy_q;
    assign bus.zero_o     = zero_q;
    assign bus.overflow_o = overflow_q;
    assign bus.missed_o   = missed_q;
    assign bus.win_state  = win_state;
    assign bus.hs_state   = hs_state;

endmodule

// File: tb/tb_rate_window_counter.sv
// Bench for rate_window_counter: a 16-bit and a 4-bit instance share the
// window/event stimulus, each has its own behavioural divider and reference.
module tb_rate_window_counter;
    import rate_window_pkg::*;

    typedef struct {
        bit running;
        int len;
        int pos;
        int cnt;
        bit busy;
        int count_out;
        bit calc;
        bit zero;
        bit missed;
        bit ovf;
    } model_t;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        ev;
    logic [23:0] len;
    logic        valid16;
    logic        valid4;

    int     checks;
    int     errors;
    int     div16;
    int     div4;
    int     lat_lo;
    int     lat_hi;
    bit     stray_en;
    int     zero_seen16;
    int     missed_seen16;
    int     density;
    model_t m16;
    model_t m4;

    logic [15:0] exp_q16[$];
    logic [3:0]  exp_q4[$];

    rate_window_counter_if #(.NBITS(16), .WINDOW_BITS(24)) bus16 ();
    rate_window_counter_if #(.NBITS(4),  .WINDOW_BITS(24)) bus4 ();

    assign bus16.enable_i      = enable;
    assign bus16.window_len_i  = len;
    assign bus16.event_i       = ev;
    assign bus16.recip_valid_i = valid16;
    assign bus4.enable_i       = enable;
    assign bus4.window_len_i   = len;
    assign bus4.event_i        = ev;
    assign bus4.recip_valid_i  = valid4;

    rate_window_counter #(.NBITS(16), .WINDOW_BITS(24)) u_dut16 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus16)
    );

    rate_window_counter #(.NBITS(4), .WINDOW_BITS(24)) u_dut4 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus4)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input string n, input model_t m, input logic [31:0] cnt,
                             input logic calc, input logic busy, input logic zero,
                             input logic missed, input logic ovf,
                             input logic run_dbg, input logic wait_dbg);
        check({n, ".count_o"},    cnt,           32'(m.count_out));
        check({n, ".calc_o"},     32'(calc),     32'(m.calc));
        check({n, ".busy_o"},     32'(busy),     32'(m.busy));
        check({n, ".zero_o"},     32'(zero),     32'(m.zero));
        check({n, ".missed_o"},   32'(missed),   32'(m.missed));
        check({n, ".overflow_o"}, 32'(ovf),      32'(m.ovf));
        check({n, ".win_state"},  32'(run_dbg),  32'(m.running));
        check({n, ".hs_state"},   32'(wait_dbg), 32'(m.busy));
    endtask

    task automatic check_both();
        check_dut("dut16", m16, 32'(bus16.count_o), bus16.calc_o, bus16.busy_o,
                  bus16.zero_o, bus16.missed_o, bus16.overflow_o,
                  bus16.win_state == WIN_RUN, bus16.hs_state == HS_WAIT);
        check_dut("dut4", m4, 32'(bus4.count_o), bus4.calc_o, bus4.busy_o,
                  bus4.zero_o, bus4.missed_o, bus4.overflow_o,
                  bus4.win_state == WIN_RUN, bus4.hs_state == HS_WAIT);
    endtask

    // ---------------- reference model ----------------
    // One clock edge of the window counter described by its rules: a window is
    // len cycles of counting after the start cycle, the count is clamped at
    // 2^nbits-1, and each window end is classified as zero / calc / missed.
    task automatic model_step(inout model_t m, input bit en, input int wlen,
                              input bit e, input bit valid, input int nbits);
        int maxv;
        bit was_busy;
        maxv     = (1 << nbits) - 1;
        was_busy = m.busy;
        m.calc   = 0;
        m.zero   = 0;
        m.missed = 0;
        if (!en) m.ovf = 0;
        if (m.running) begin
            if (!en) begin
                m.running = 0;
            end else begin
                m.pos++;
                if (e) begin
                    if (m.cnt == maxv) m.ovf = 1;
                    else m.cnt++;
                end
                if (m.pos == m.len) begin
                    if (m.cnt == 0) begin
                        m.zero = 1;
                    end else if (was_busy) begin
                        m.missed = 1;
                    end else begin
                        m.count_out = m.cnt;
                        m.calc      = 1;
                        m.busy      = 1;
                    end
                    m.len = (wlen == 0) ? 1 : wlen;
                    m.pos = 0;
                    m.cnt = 0;
                end
            end
        end else if (en) begin
            m.running = 1;
            m.len     = (wlen == 0) ? 1 : wlen;
            m.pos     = 0;
            m.cnt     = 0;
        end
        if (was_busy && valid) m.busy = 0;
    endtask

    // ---------------- driver ----------------
    // Advance one clock: present the divider's valid, step the references,
    // then check both instances just after the edge.
    task automatic step();
        valid16 = (div16 == 0);
        valid4  = (div4 == 0);
        if (stray_en && !m16.busy && div16 < 0 && $urandom_range(0, 39) == 0) valid16 = 1'b1;
        if (stray_en && !m4.busy && div4 < 0 && $urandom_range(0, 39) == 0) valid4 = 1'b1;
        model_step(m16, enable, int'(len), ev, valid16, 16);
        model_step(m4,  enable, int'(len), ev, valid4,  4);
        @(posedge clk);
        #1;
        if (div16 >= 0) div16--;
        if (div4 >= 0) div4--;
        if (m16.calc) div16 = $urandom_range(lat_lo, lat_hi);
        if (m4.calc) div4 = $urandom_range(lat_lo, lat_hi);
        check_both();
        if (m16.calc) exp_q16.push_back(16'(m16.count_out));
        if (m4.calc) exp_q4.push_back(4'(m4.count_out));
        if (bus16.calc_o) begin
            if (exp_q16.size() == 0) check("dut16.calc_unexpected", 32'(bus16.calc_o), 0);
            else check("dut16.sb_count", 32'(bus16.count_o), 32'(exp_q16.pop_front()));
        end
        if (bus4.calc_o) begin
            if (exp_q4.size() == 0) check("dut4.calc_unexpected", 32'(bus4.calc_o), 0);
            else check("dut4.sb_count", 32'(bus4.count_o), 32'(exp_q4.pop_front()));
        end
        zero_seen16   += int'(bus16.zero_o);
        missed_seen16 += int'(bus16.missed_o);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asynchronous reset away from the clock edge, checked immediately.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        m16 = '{default: 0};
        m4  = '{default: 0};
        exp_q16.delete();
        exp_q4.delete();
        check_both();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_both();
        #2;
        rst = 1'b0;
    endtask

    // ---------------- directed and random sequence ----------------
    initial begin
        checks   = 0;
        errors   = 0;
        div16    = -1;
        div4     = -1;
        lat_lo   = 19;
        lat_hi   = 19;
        stray_en = 0;
        density  = 30;
        enable   = 1'b0;
        ev       = 1'b0;
        len      = '0;
        valid16  = 1'b0;
        valid4   = 1'b0;
        rst      = 1'b1;
        m16      = '{default: 0};
        m4       = '{default: 0};

        // Reset state
        #12;
        check_both();
        @(posedge clk);
        #3;
        rst = 1'b0;
        steps(3);

        // 25 events spread over a 100-cycle window
        enable = 1'b1;
        len    = 24'd100;
        step();
        for (int k = 1; k <= 100; k++) begin
            ev = (k % 4 == 0);
            step();
        end
        check("a.calc", 32'(bus16.calc_o), 1);
        check("a.count", 32'(bus16.count_o), 25);
        ev     = 1'b0;
        enable = 1'b0;
        steps(10);
        check("a.count_held", 32'(bus16.count_o), 25);
        check("a.busy_held", 32'(bus16.busy_o), 1);
        steps(20);
        check("a.busy_done", 32'(bus16.busy_o), 0);

        // Empty windows of 50 cycles
        zero_seen16 = 0;
        enable = 1'b1;
        len    = 24'd50;
        steps(151);
        check("b.zero_pulses", 32'(zero_seen16), 3);
        check("b.busy", 32'(bus16.busy_o), 0);
        enable = 1'b0;
        steps(2);

        // Saturation with event held high
        enable = 1'b1;
        len    = 24'd40;
        ev     = 1'b1;
        steps(41);
        check("c.calc16", 32'(bus16.calc_o), 1);
        check("c.count16", 32'(bus16.count_o), 40);
        check("c.count4", 32'(bus4.count_o), 15);
        check("c.ovf4", 32'(bus4.overflow_o), 1);
        ev = 1'b0;
        steps(5);
        check("c.ovf4_sticky", 32'(bus4.overflow_o), 1);
        enable = 1'b0;
        step();
        check("c.ovf4_cleared", 32'(bus4.overflow_o), 0);
        steps(30);

        // Short windows while the divider is busy
        missed_seen16 = 0;
        enable = 1'b1;
        len    = 24'd8;
        step();
        for (int k = 1; k <= 32; k++) begin
            ev = (k % 2 == 0) && (k % 8 != 0);
            step();
        end
        check("d.missed", 32'(missed_seen16), 2);
        check("d.calc", 32'(bus16.calc_o), 1);
        check("d.count", 32'(bus16.count_o), 3);
        ev     = 1'b0;
        enable = 1'b0;
        steps(30);

        // Event on the terminal cycle only
        enable = 1'b1;
        len    = 24'd10;
        step();
        for (int k = 1; k <= 10; k++) begin
            ev = (k == 10);
            step();
        end
        check("e.calc", 32'(bus16.calc_o), 1);
        check("e.count", 32'(bus16.count_o), 1);
        ev     = 1'b0;
        enable = 1'b0;
        steps(30);

        // Zero window length: every cycle ends a window
        enable = 1'b1;
        len    = '0;
        for (int k = 0; k < 12; k++) begin
            ev = 1'($urandom_range(0, 1));
            step();
        end
        ev     = 1'b0;
        enable = 1'b0;
        steps(30);

        // Random windows, events, enable toggles, divider latency, stray valids
        lat_lo   = 3;
        lat_hi   = 30;
        stray_en = 1;
        enable   = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            if ($urandom_range(0, 299) == 0) density = $urandom_range(0, 100);
            len = 24'($urandom_range(0, 40));
            ev  = ($urandom_range(0, 99) < density);
            step();
        end
        stray_en = 0;
        enable   = 1'b0;
        ev       = 1'b0;
        steps(40);

        // Reset while waiting on the divider; its late valid must be ignored
        lat_lo = 19;
        lat_hi = 19;
        enable = 1'b1;
        len    = 24'd5;
        ev     = 1'b1;
        steps(6);
        check("h.calc", 32'(bus16.calc_o), 1);
        steps(3);
        check("h.busy_before", 32'(bus16.busy_o), 1);
        do_reset();
        enable = 1'b0;
        ev     = 1'b0;
        steps(30);
        check("h.busy_after", 32'(bus16.busy_o), 0);
        check("h.count_after", 32'(bus16.count_o), 0);

        check("end.queue16", 32'(exp_q16.size()), 0);
        check("end.queue4", 32'(exp_q4.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
